// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - SPI frame engine reading a 12-bit, 8-channel ADC
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   channel_addr    channel to address in the next frame
//   enable          level; frames run back to back while high
//   adc_cs_n        ADC chip select, active low
//   adc_sclk        SPI clock, idles high, half-period CLK_DIV clks
//   adc_mosi        address bits to ADC, changed on sclk falling edges
//   adc_miso        conversion data from ADC, sampled on sclk rising edges
//   sample          last 12-bit conversion result
//   sample_channel  channel the result belongs to (addressed one frame earlier)
//   sample_valid    one-clk pulse when sample/sample_channel update
//   busy            high whenever a frame or inter-frame gap is in progress
module adc_spi_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  channel_addr,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [11:0] sample,
  output logic [2:0]  sample_channel,
  output logic        sample_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [11:0] shreg;
  logic [2:0]  cur_ch;
  logic [2:0]  prev_ch;

  logic        half_end;
  logic        last_bit;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        frame_start;
  logic [3:0]  next_bit;
  logic        mosi_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    half_end  = (cnt == HALF_LAST);
    last_bit  = (bit_cnt == 4'd15);
    // adc_sclk doubles as the phase flag inside SHIFT: 0 = low half, 1 = high half
    sclk_rise = (state == SHIFT) && half_end && !adc_sclk;
    sclk_fall = (state == SHIFT) && half_end && adc_sclk && !last_bit;
    next_bit  = bit_cnt + 4'd1;

    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETUP;
      SETUP:   if (half_end) state_nxt = SHIFT;
      SHIFT:   if (half_end && adc_sclk && last_bit) state_nxt = DONE;
      DONE:    state_nxt = GAP;
      GAP:     if (cnt == GAP_LAST) state_nxt = enable ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase

    frame_start = (state_nxt == SETUP) && (state != SETUP);

    // Address bit for the period that starts at this falling edge
    mosi_next = 1'b0;
    case (next_bit)
      4'd2:    mosi_next = cur_ch[2];
      4'd3:    mosi_next = cur_ch[1];
      4'd4:    mosi_next = cur_ch[0];
      default: mosi_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      cur_ch         <= '0;
      prev_ch        <= '0;
      adc_cs_n       <= 1'b1;
      adc_sclk       <= 1'b1;
      adc_mosi       <= 1'b0;
      sample         <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Outputs decoded from the next state so they line up with the state register
      adc_cs_n     <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
      busy         <= (state_nxt != IDLE);
      sample_valid <= (state_nxt == DONE);

      if ((state != state_nxt) || (state == IDLE) || ((state == SHIFT) && half_end)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 9'd1;
      end

      if (frame_start) begin
        cur_ch  <= channel_addr;
        bit_cnt <= '0;
        shreg   <= '0;
      end

      if ((state == SETUP) && half_end) begin
        adc_sclk <= 1'b0;
      end else if (sclk_rise) begin
        adc_sclk <= 1'b1;
      end else if (sclk_fall) begin
        adc_sclk <= 1'b0;
        adc_mosi <= mosi_next;
        bit_cnt  <= next_bit;
      end

      // First four periods carry no data bits from the ADC
      if (sclk_rise && (bit_cnt >= 4'd4)) begin
        shreg <= {shreg[10:0], adc_miso};
      end

      // The ADC returns the conversion addressed one frame earlier
      if ((state == SHIFT) && (state_nxt == DONE)) begin
        sample         <= shreg;
        sample_channel <= prev_ch;
        prev_ch        <= cur_ch;
      end
    end
  end

endmodule
